vga_mem_arbiter_rr: RTL
=======================

Name: vga_mem_arbiter_rr

Overview:
- Parametrised N-channel arbiter between the pixel-pipeline clients and the single-port frame memory.
- Clients include the colour buffers, the display fetch and the drawing engine.
- Each client issues read/write beats over an rts/rtr handshake.
- Grants are held for a burst, selected by round-robin or fixed priority (run-time mode).
- Read data is routed back to the originating channel after the memory's fixed latency.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
ADDR_W, 19, memory address width
DATA_W, 32, memory data width
MEM_LAT, 2, cycles from registered mem_en (read) to valid mem_rdata (1..4)
MAX_BURST, 8, maximum beats per grant before forced release (1..16)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_  in  1  synchronous active-low reset
enable  in  1  global enable; low blocks new grants and beat acceptance
mode  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
req_rts  in  NUM_CH  per-channel beat ready-to-send
req_last  in  NUM_CH  beat is last of burst
req_we  in  NUM_CH  1 = write beat, 0 = read beat
req_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CH*DATA_W  packed write data
arb_rtr  out  NUM_CH  beat accepted when req_rts[i] & arb_rtr[i]
grant  out  NUM_CH  one-hot current owner, zero when idle
mem_en  out  1  registered memory strobe
mem_we  out  1  registered write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data
rsp_valid  out  NUM_CH  one-hot read-return strobe, no backpressure
rsp_data  out  DATA_W  registered read data, shared by all channels

Behaviour:
- Reset (rst_=0 at edge):
  - state=ARB; grant, arb_rtr, mem_en, mem_we, rsp_valid = 0.
  - mem_addr, mem_wdata, rsp_data = 0.
  - RR pointer = NUM_CH-1, so channel 0 is searched first.
  - Beat counter = 0; return-tag pipeline cleared.
- State ARB:
  - If enable and any req_rts: select a winner, grant <= onehot(winner), beat counter <= 0, go to BURST.
  - Otherwise remain in ARB.
  - arb_rtr = 0 in ARB.
- Winner selection:
  - mode=1: lowest-index requesting channel.
  - mode=0: first requesting channel searching upward from pointer+1 modulo NUM_CH; pointer <= winner on grant.
  - mode is sampled only in ARB; changing it mid-burst has no effect until the next arbitration.
- State BURST:
  - arb_rtr[i] = enable & grant[i] (combinational); all other channels read 0.
  - Accepted beat: the next cycle mem_en=1 and mem_we/mem_addr/mem_wdata come from the owner's slice; counter increments.
  - No accepted beat in a cycle: mem_en=0 next cycle.
  - Release (grant <= 0, go to ARB) on the first of:
    - accepted beat with req_last=1;
    - accepted beat that makes the count equal MAX_BURST;
    - owner's req_rts low while enable=1.
  - enable low in BURST: hold the grant, accept nothing, no release.
- Arbitration gap: one ARB cycle between grants; sustained throughput is at most MAX_BURST beats per MAX_BURST+1 cycles.
- Read return:
  - Each read beat pushes the owner index into a MEM_LAT+1 deep tag shift register with a valid bit.
  - At tag exit: rsp_valid <= onehot(tag), rsp_data <= mem_rdata.
  - rsp_valid asserts exactly MEM_LAT+1 cycles after mem_en, i.e. MEM_LAT+2 cycles after the accepting edge.
  - Write beats push an invalid tag.
  - Back-to-back reads return back-to-back, in order.
- In-flight reads:
  - Always returned even if the grant moved, enable dropped, or mode changed.
  - Reset discards them: no rsp_valid after reset.
- Simultaneous events:
  - release and new request on the same edge: the new request is evaluated in the following ARB cycle;
  - last beat with req_last and count reaching MAX_BURST on the same beat: a single release.
- Width rules:
  - Beat counter width is clog2(MAX_BURST+1).
  - Pointer and tag width are clog2(NUM_CH), minimum 1.

Test Plan:
- Reset then ch1 reads addr 0x100..0x103 with last on beat 4, mem model returns addr+0xA000 -> grant=4'b0010 one cycle after rts; mem_en 4 consecutive cycles; rsp_valid=4'b0010 with data 0xA100..0xA103 starting 4 cycles after the first acceptance (MEM_LAT=2); grant=0 after beat 4.
- mode=0, all four channels request continuous 2-beat bursts -> grant order ch0,ch1,ch2,ch3,ch0; one idle ARB cycle between grants; rsp_valid tags match issuing channel.
- mode=1, ch0 and ch3 requesting continuously -> ch0 wins every arbitration; ch3 is never granted while ch0 has req_rts high.
- ch2 issues a 10-beat read with no req_last (MAX_BURST=8) -> release after 8 accepted beats; regrant for the remaining 2; 10 in-order responses.
- ch0 writes 0xDEADBEEF to 0x7FFFF, then reads it back -> mem_we=1 with correct addr/data; no rsp_valid for the write; read returns 0xDEADBEEF.
- Reset asserted one cycle after the 3rd read of a burst -> all outputs 0 next cycle; no rsp_valid afterwards; fresh ch0 request granted normally.

Source files
------------

// File: rtl/vga_mem_arbiter_rr.sv
// rtl/vga_mem_arbiter_rr.sv - N-channel burst arbiter with read-return routing for the frame memory
module vga_mem_arbiter_rr #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        req_rts,
    input  logic [NUM_CH-1:0]        req_last,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        arb_rtr,
    output logic [NUM_CH-1:0]        grant,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_data
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int TAG_D = MEM_LAT + 1;

    typedef enum logic {ARB, BURST} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  own_idx;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    rr_cand;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_cnt_nxt;
    logic [TAG_D-1:0]  tag_vld;
    logic [IDX_W-1:0]  tag_idx [TAG_D];

    logic              own_rts;
    logic              own_last;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              beat_acc;
    logic              burst_end;

    // Owner's beat fields, selected by the one-hot grant
    always_comb begin
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign own_rts      = |(req_rts & grant);
    assign own_last     = |(req_last & grant);
    assign own_we       = |(req_we & grant);
    assign arb_rtr      = (state == BURST && enable) ? grant : '0;
    assign beat_acc     = (state == BURST) && enable && own_rts;
    assign beat_cnt_nxt = beat_cnt + CNT_W'(1);
    assign burst_end    = own_last || (beat_cnt_nxt == CNT_W'(MAX_BURST));

    // Winner search; later loop iterations have higher priority
    always_comb begin
        win_idx = '0;
        rr_cand = '0;
        if (mode) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req_rts[i]) begin
                    win_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                rr_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (rr_cand >= (IDX_W+1)'(NUM_CH)) begin
                    rr_cand = rr_cand - (IDX_W+1)'(NUM_CH);
                end
                if (req_rts[rr_cand[IDX_W-1:0]]) begin
                    win_idx = rr_cand[IDX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= ARB;
            grant     <= '0;
            own_idx   <= '0;
            rr_ptr    <= IDX_W'(NUM_CH - 1);
            beat_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= beat_acc;
            mem_we <= beat_acc & own_we;
            if (beat_acc) begin
                mem_addr  <= own_addr;
                mem_wdata <= own_wdata;
                beat_cnt  <= beat_cnt_nxt;
            end
            case (state)
                ARB: begin
                    if (enable && (|req_rts)) begin
                        grant    <= NUM_CH'(1) << win_idx;
                        own_idx  <= win_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                        if (!mode) begin
                            rr_ptr <= win_idx;
                        end
                    end
                end
                BURST: begin
                    // Disabled bursts freeze: no accept, no release
                    if (enable && (!own_rts || burst_end)) begin
                        grant <= '0;
                        state <= ARB;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ARB;
                end
            endcase
        end
    end

    // Tag pipeline aligned with memory latency; only read beats carry a valid tag
    always_ff @(posedge clk) begin
        if (!rst_) begin
            tag_vld   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int i = 0; i < TAG_D; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            tag_vld    <= {tag_vld[TAG_D-2:0], beat_acc & ~own_we};
            tag_idx[0] <= own_idx;
            for (int i = 1; i < TAG_D; i++) begin
                tag_idx[i] <= tag_idx[i-1];
            end
            rsp_valid <= tag_vld[TAG_D-1] ? (NUM_CH'(1) << tag_idx[TAG_D-1]) : '0;
            if (tag_vld[TAG_D-1]) begin
                rsp_data <= mem_rdata;
            end
        end
    end
endmodule
